// File: rtl/mtimer_unit.sv
// mtimer_unit: 64-bit machine timer (mtime/mtimecmp) with prescaler, 32-bit register port
// and a registered level timer interrupt request.
module mtimer_unit #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        reg_valid,
    input  logic        reg_wr,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic        reg_ready,
    output logic [31:0] reg_rdata,
    output logic        timer_int
);
    logic [63:0]               mtime;
    logic [63:0]               mtimecmp;
    logic [31:0]               hi_shadow;
    logic [31:0]               rd_val;
    logic [PRESCALE_WIDTH-1:0] div;
    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic                      en;
    logic                      accept;
    logic                      wr_acc;
    logic                      tick;
    logic                      cmp_hit;
    logic [2:0]                word;
    logic                      addr_unused;

    assign word        = reg_addr[4:2];
    assign addr_unused = ^reg_addr[1:0];
    assign accept      = reg_valid & ~reg_ready;
    assign wr_acc      = accept & reg_wr;
    assign tick        = en & (pcnt == div);
    assign cmp_hit     = en & (mtime >= mtimecmp);

    always_comb begin
        rd_val = 32'd0;
        case (word)
            3'd0:    rd_val = mtime[31:0];
            3'd1:    rd_val = hi_shadow;
            3'd2:    rd_val = mtimecmp[31:0];
            3'd3:    rd_val = mtimecmp[63:32];
            3'd4:    rd_val = 32'({div, 7'd0, en});
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            mtime     <= 64'd0;
            mtimecmp  <= '1;
            en        <= 1'b0;
            div       <= '0;
            pcnt      <= '0;
            hi_shadow <= 32'd0;
            reg_ready <= 1'b0;
            reg_rdata <= 32'd0;
            timer_int <= 1'b0;
        end else begin
            reg_ready <= accept;
            timer_int <= cmp_hit;
            if (accept)
                reg_rdata <= rd_val;
            if (accept && !reg_wr && word == 3'd0)
                hi_shadow <= mtime[63:32];
            pcnt <= ((wr_acc && word == 3'd4) || !en || tick) ? '0 : pcnt + 1'b1;
            // a write to either mtime half swallows a coincident tick
            if (wr_acc && word == 3'd0)
                mtime[31:0] <= reg_wdata;
            else if (wr_acc && word == 3'd1)
                mtime[63:32] <= reg_wdata;
            else if (tick)
                mtime <= mtime + 64'd1;
            if (wr_acc && word == 3'd2)
                mtimecmp[31:0] <= reg_wdata;
            if (wr_acc && word == 3'd3)
                mtimecmp[63:32] <= reg_wdata;
            if (wr_acc && word == 3'd4) begin
                en  <= reg_wdata[0];
                div <= reg_wdata[8 +: PRESCALE_WIDTH];
            end
        end
    end
endmodule
